result_tx_interface: RTL and testbench

Return path of the ALU datapath. It captures the ALU result when a valid pulse arrives and splits it into bytes, least significant byte first. It feeds those bytes one at a time to the UART transmitter using a start/done handshake. It sits between the ALU output and the UART TX block, opposite the operand/opcode loading interface.

---
 rtl/result_tx_interface.sv | 157 +++++++++++++++
 tb/tb_result_tx_interface.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/result_tx_interface.sv
// result_tx_interface
// Return path of the ALU datapath. Captures an ALU result on a valid pulse and
// sends it to the UART transmitter one byte at a time, least significant byte
// first, using a start/done handshake.
//
// Handshake: o_tx_start is a one-cycle request to send o_tx_data; the UART
// answers with a one-cycle i_tx_done when that byte has gone out. The next
// request follows one cycle after i_tx_done. i_tx_done outside the wait state
// is ignored. A result offered while a transfer is in progress is dropped and
// flagged with a one-cycle o_overrun pulse.
//
// Optional feature: define RESULT_TX_CHECKSUM_EN to append one byte holding the
// XOR of all data bytes after the last data byte.
//
// Ports:
//   i_clock        system clock, rising edge
//   i_reset        synchronous reset, active low
//   i_result       ALU result (CANT_BITS_RESULTADO bits)
//   i_result_valid one-cycle pulse, i_result valid
//   i_tx_done      one-cycle pulse from UART TX, current byte finished
//   o_tx_start     one-cycle pulse, UART TX must send o_tx_data
//   o_tx_data      byte to transmit (held after the transfer)
//   o_busy         high while a result is being sent
//   o_overrun      one-cycle pulse when a result is dropped
module result_tx_interface #(
  parameter int CANT_BITS_RESULTADO = 8,
  parameter int WIDTH_WORD_TX       = 8
) (
  input  logic                           i_clock,
  input  logic                           i_reset,
  input  logic [CANT_BITS_RESULTADO-1:0] i_result,
  input  logic                           i_result_valid,
  input  logic                           i_tx_done,
  output logic                           o_tx_start,
  output logic [WIDTH_WORD_TX-1:0]       o_tx_data,
  output logic                           o_busy,
  output logic                           o_overrun
);

  localparam int CANT_BYTES = (CANT_BITS_RESULTADO + 7) / 8;
  localparam int SW         = CANT_BYTES * 8;
  localparam int CW         = $clog2(CANT_BYTES + 1);
  localparam logic [CW-1:0] LAST_IDX = CW'(CANT_BYTES - 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    START     = 2'd1,
    WAIT_DONE = 2'd2
  } state_t;

  state_t                   state_q, state_d;
  logic [SW-1:0]            shift_q, shift_d;
  logic [CW-1:0]            cnt_q, cnt_d;
  logic                     tx_start_q, tx_start_d;
  logic [WIDTH_WORD_TX-1:0] tx_data_q, tx_data_d;
  logic                     busy_q, busy_d;
  logic                     overrun_q, overrun_d;
`ifdef RESULT_TX_CHECKSUM_EN
  // Counter value CANT_BYTES marks the checksum byte phase.
  localparam logic [CW-1:0] CSUM_IDX = CW'(CANT_BYTES);
  logic [7:0]               csum_q, csum_d;
`endif

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    cnt_d     = cnt_q;
    tx_data_d = tx_data_q;
    // Any valid outside IDLE is dropped, including the cycle of the final done.
    overrun_d = i_result_valid && (state_q != IDLE);
`ifdef RESULT_TX_CHECKSUM_EN
    csum_d    = csum_q;
`endif

    case (state_q)
      IDLE: begin
        if (i_result_valid) begin
          shift_d   = SW'(i_result);
          cnt_d     = '0;
          tx_data_d = shift_d[WIDTH_WORD_TX-1:0];
`ifdef RESULT_TX_CHECKSUM_EN
          csum_d    = shift_d[7:0];
`endif
          state_d   = START;
        end
      end
      START: begin
        state_d = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (i_tx_done) begin
`ifdef RESULT_TX_CHECKSUM_EN
          if (cnt_q == CSUM_IDX) begin
            state_d = IDLE;
          end else if (cnt_q == LAST_IDX) begin
            cnt_d     = cnt_q + CW'(1);
            tx_data_d = WIDTH_WORD_TX'(csum_q);
            state_d   = START;
          end else begin
            shift_d   = shift_q >> 8;
            cnt_d     = cnt_q + CW'(1);
            tx_data_d = shift_d[WIDTH_WORD_TX-1:0];
            csum_d    = csum_q ^ shift_d[7:0];
            state_d   = START;
          end
`else
          if (cnt_q == LAST_IDX) begin
            state_d = IDLE;
          end else begin
            shift_d   = shift_q >> 8;
            cnt_d     = cnt_q + CW'(1);
            tx_data_d = shift_d[WIDTH_WORD_TX-1:0];
            state_d   = START;
          end
`endif
        end
      end
      default: state_d = IDLE;
    endcase

    // Outputs are registered from the next state so they line up with it.
    tx_start_d = (state_d == START);
    busy_d     = (state_d != IDLE);
  end

  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      state_q    <= IDLE;
      shift_q    <= '0;
      cnt_q      <= '0;
      tx_start_q <= 1'b0;
      tx_data_q  <= '0;
      busy_q     <= 1'b0;
      overrun_q  <= 1'b0;
`ifdef RESULT_TX_CHECKSUM_EN
      csum_q     <= '0;
`endif
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      cnt_q      <= cnt_d;
      tx_start_q <= tx_start_d;
      tx_data_q  <= tx_data_d;
      busy_q     <= busy_d;
      overrun_q  <= overrun_d;
`ifdef RESULT_TX_CHECKSUM_EN
      csum_q     <= csum_d;
`endif
    end
  end

  assign o_tx_start = tx_start_q;
  assign o_tx_data  = tx_data_q;
  assign o_busy     = busy_q;
  assign o_overrun  = overrun_q;

endmodule

// File: tb/tb_result_tx_interface.sv
module tb_result_tx_interface;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // 8-bit instance
  logic [7:0]  r8;
  logic        v8, d8, st8, b8, ov8;
  logic [7:0]  dt8;
  // 16-bit instance
  logic [15:0] r16;
  logic        v16, d16, st16, b16, ov16;
  logic [7:0]  dt16;

  int total = 0;
  int bad   = 0;
  int n8    = 0;
  int n16   = 0;

  result_tx_interface #(.CANT_BITS_RESULTADO(8), .WIDTH_WORD_TX(8)) u8 (
    .i_clock(clk), .i_reset(rst_n), .i_result(r8), .i_result_valid(v8),
    .i_tx_done(d8), .o_tx_start(st8), .o_tx_data(dt8), .o_busy(b8),
    .o_overrun(ov8)
  );

  result_tx_interface #(.CANT_BITS_RESULTADO(16), .WIDTH_WORD_TX(8)) u16 (
    .i_clock(clk), .i_reset(rst_n), .i_result(r16), .i_result_valid(v16),
    .i_tx_done(d16), .o_tx_start(st16), .o_tx_data(dt16), .o_busy(b16),
    .o_overrun(ov16)
  );

  // Start-pulse counters, sampled mid-cycle.
  always @(negedge clk) begin
    if (st8)  n8++;
    if (st16) n16++;
  end

  task automatic cyc(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_done16();
    d16 = 1'b1; cyc(); d16 = 1'b0;
  endtask

  task automatic pulse_done8();
    d8 = 1'b1; cyc(); d8 = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    r8 = '0; v8 = 0; d8 = 0; r16 = '0; v16 = 0; d16 = 0;
    cyc(3);
    total++; if (st8 !== 1'b0)   begin bad++; $display("FAIL reset_start8 got=%b exp=0", st8); end
    total++; if (dt8 !== 8'h00)  begin bad++; $display("FAIL reset_data8 got=%h exp=00", dt8); end
    total++; if (b8 !== 1'b0)    begin bad++; $display("FAIL reset_busy8 got=%b exp=0", b8); end
    total++; if (ov8 !== 1'b0)   begin bad++; $display("FAIL reset_ovr8 got=%b exp=0", ov8); end
    total++; if (st16 !== 1'b0)  begin bad++; $display("FAIL reset_start16 got=%b exp=0", st16); end
    total++; if (dt16 !== 8'h00) begin bad++; $display("FAIL reset_data16 got=%h exp=00", dt16); end
    total++; if (b16 !== 1'b0)   begin bad++; $display("FAIL reset_busy16 got=%b exp=0", b16); end
    total++; if (ov16 !== 1'b0)  begin bad++; $display("FAIL reset_ovr16 got=%b exp=0", ov16); end
    rst_n = 1'b1;
    cyc();
  endtask

  task automatic test_single_byte();
    int n0 = n8;
    r8 = 8'hA5; v8 = 1'b1; cyc(); v8 = 1'b0;
    total++; if (st8 !== 1'b1)  begin bad++; $display("FAIL t1_start got=%b exp=1", st8); end
    total++; if (dt8 !== 8'hA5) begin bad++; $display("FAIL t1_data got=%h exp=a5", dt8); end
    total++; if (b8 !== 1'b1)   begin bad++; $display("FAIL t1_busy got=%b exp=1", b8); end
    cyc(9);
    total++; if (st8 !== 1'b0 || b8 !== 1'b1 || dt8 !== 8'hA5)
      begin bad++; $display("FAIL t1_wait got=%b/%b/%h exp=0/1/a5", st8, b8, dt8); end
    pulse_done8();
`ifdef RESULT_TX_CHECKSUM_EN
    total++; if (st8 !== 1'b1 || dt8 !== 8'hA5)
      begin bad++; $display("FAIL t1_csum got=%b/%h exp=1/a5", st8, dt8); end
    cyc(3);
    pulse_done8();
`endif
    total++; if (b8 !== 1'b0)  begin bad++; $display("FAIL t1_busy_fall got=%b exp=0", b8); end
    total++; if (st8 !== 1'b0) begin bad++; $display("FAIL t1_idle_start got=%b exp=0", st8); end
    total++; if (dt8 !== 8'hA5) begin bad++; $display("FAIL t1_data_hold got=%h exp=a5", dt8); end
    cyc(5);
`ifdef RESULT_TX_CHECKSUM_EN
    total++; if (n8 - n0 !== 2) begin bad++; $display("FAIL t1_count got=%0d exp=2", n8 - n0); end
`else
    total++; if (n8 - n0 !== 1) begin bad++; $display("FAIL t1_count got=%0d exp=1", n8 - n0); end
`endif
  endtask

  task automatic test_two_bytes();
    int n0 = n16;
    r16 = 16'h1234; v16 = 1'b1; cyc(); v16 = 1'b0;
    total++; if (st16 !== 1'b1 || dt16 !== 8'h34)
      begin bad++; $display("FAIL t2_b0 got=%b/%h exp=1/34", st16, dt16); end
    cyc(3);
    pulse_done16();
    total++; if (st16 !== 1'b1 || dt16 !== 8'h12)
      begin bad++; $display("FAIL t2_b1 got=%b/%h exp=1/12", st16, dt16); end
    cyc(3);
    pulse_done16();
`ifdef RESULT_TX_CHECKSUM_EN
    total++; if (st16 !== 1'b1 || dt16 !== 8'h26 || b16 !== 1'b1)
      begin bad++; $display("FAIL t2_csum got=%b/%h/%b exp=1/26/1", st16, dt16, b16); end
    cyc(2);
    pulse_done16();
`endif
    total++; if (b16 !== 1'b0) begin bad++; $display("FAIL t2_busy_fall got=%b exp=0", b16); end
    cyc(4);
`ifdef RESULT_TX_CHECKSUM_EN
    total++; if (n16 - n0 !== 3) begin bad++; $display("FAIL t2_count got=%0d exp=3", n16 - n0); end
`else
    total++; if (n16 - n0 !== 2) begin bad++; $display("FAIL t2_count got=%0d exp=2", n16 - n0); end
`endif
  endtask

  task automatic test_overrun();
    int n0 = n8;
    r8 = 8'h11; v8 = 1'b1; cyc(); v8 = 1'b0;
    total++; if (st8 !== 1'b1 || dt8 !== 8'h11)
      begin bad++; $display("FAIL t3_start got=%b/%h exp=1/11", st8, dt8); end
    cyc(2);
    r8 = 8'h22; v8 = 1'b1; cyc(); v8 = 1'b0;
    total++; if (ov8 !== 1'b1 || dt8 !== 8'h11 || st8 !== 1'b0)
      begin bad++; $display("FAIL t3_ovr got=%b/%h/%b exp=1/11/0", ov8, dt8, st8); end
    cyc();
    total++; if (ov8 !== 1'b0) begin bad++; $display("FAIL t3_ovr_pulse got=%b exp=0", ov8); end
    cyc(2);
    // A valid coinciding with done is dropped too.
    r8 = 8'h33; v8 = 1'b1; d8 = 1'b1; cyc(); v8 = 1'b0; d8 = 1'b0;
    total++; if (ov8 !== 1'b1) begin bad++; $display("FAIL t3_ovr_done got=%b exp=1", ov8); end
`ifdef RESULT_TX_CHECKSUM_EN
    total++; if (st8 !== 1'b1 || dt8 !== 8'h11)
      begin bad++; $display("FAIL t3_csum got=%b/%h exp=1/11", st8, dt8); end
    cyc(2);
    pulse_done8();
`endif
    total++; if (b8 !== 1'b0) begin bad++; $display("FAIL t3_busy_fall got=%b exp=0", b8); end
    cyc(6);
    total++; if (b8 !== 1'b0 || dt8 !== 8'h11)
      begin bad++; $display("FAIL t3_no_rearm got=%b/%h exp=0/11", b8, dt8); end
`ifdef RESULT_TX_CHECKSUM_EN
    total++; if (n8 - n0 !== 2) begin bad++; $display("FAIL t3_count got=%0d exp=2", n8 - n0); end
`else
    total++; if (n8 - n0 !== 1) begin bad++; $display("FAIL t3_count got=%0d exp=1", n8 - n0); end
`endif
  endtask

  task automatic test_reset_mid();
    r16 = 16'hBEEF; v16 = 1'b1; cyc(); v16 = 1'b0;
    total++; if (dt16 !== 8'hEF) begin bad++; $display("FAIL t4_b0 got=%h exp=ef", dt16); end
    cyc(2);
    pulse_done16();
    total++; if (st16 !== 1'b1 || dt16 !== 8'hBE)
      begin bad++; $display("FAIL t4_b1 got=%b/%h exp=1/be", st16, dt16); end
    cyc();
    rst_n = 1'b0; cyc(); rst_n = 1'b1;
    total++; if (b16 !== 1'b0 || st16 !== 1'b0 || dt16 !== 8'h00)
      begin bad++; $display("FAIL t4_rst got=%b/%b/%h exp=0/0/00", b16, st16, dt16); end
    total++; if (u16.state_q !== 2'd0)
      begin bad++; $display("FAIL t4_state got=%0d exp=0", u16.state_q); end
    cyc(2);
    r16 = 16'h0102; v16 = 1'b1; cyc(); v16 = 1'b0;
    total++; if (st16 !== 1'b1 || dt16 !== 8'h02)
      begin bad++; $display("FAIL t4_new_b0 got=%b/%h exp=1/02", st16, dt16); end
    cyc(2);
    pulse_done16();
    total++; if (st16 !== 1'b1 || dt16 !== 8'h01)
      begin bad++; $display("FAIL t4_new_b1 got=%b/%h exp=1/01", st16, dt16); end
    cyc(2);
    pulse_done16();
`ifdef RESULT_TX_CHECKSUM_EN
    total++; if (st16 !== 1'b1 || dt16 !== 8'h03)
      begin bad++; $display("FAIL t4_csum got=%b/%h exp=1/03", st16, dt16); end
    cyc(2);
    pulse_done16();
`endif
    total++; if (b16 !== 1'b0) begin bad++; $display("FAIL t4_busy_fall got=%b exp=0", b16); end
  endtask

  task automatic test_spurious_done();
    int n0;
    cyc(2);
    n0 = n16;
    pulse_done16();
    cyc(2);
    total++; if (st16 !== 1'b0 || b16 !== 1'b0 || n16 !== n0)
      begin bad++; $display("FAIL t5_idle got=%b/%b/%0d exp=0/0/%0d", st16, b16, n16, n0); end
    r16 = 16'h00AB; v16 = 1'b1; cyc(); v16 = 1'b0;
    // Now in the start cycle; a done here must not advance the transfer.
    pulse_done16();
    total++; if (st16 !== 1'b0 || b16 !== 1'b1 || dt16 !== 8'hAB)
      begin bad++; $display("FAIL t5_start got=%b/%b/%h exp=0/1/ab", st16, b16, dt16); end
    cyc(3);
    total++; if (st16 !== 1'b0) begin bad++; $display("FAIL t5_no_extra got=%b exp=0", st16); end
    pulse_done16();
    total++; if (st16 !== 1'b1 || dt16 !== 8'h00)
      begin bad++; $display("FAIL t5_b1 got=%b/%h exp=1/00", st16, dt16); end
    cyc(2);
    pulse_done16();
`ifdef RESULT_TX_CHECKSUM_EN
    total++; if (st16 !== 1'b1 || dt16 !== 8'hAB)
      begin bad++; $display("FAIL t5_csum got=%b/%h exp=1/ab", st16, dt16); end
    cyc(2);
    pulse_done16();
`endif
    total++; if (b16 !== 1'b0) begin bad++; $display("FAIL t5_busy_fall got=%b exp=0", b16); end
  endtask

  task automatic test_checksum();
`ifdef RESULT_TX_CHECKSUM_EN
    r16 = 16'h0F3C; v16 = 1'b1; cyc(); v16 = 1'b0;
    total++; if (st16 !== 1'b1 || dt16 !== 8'h3C)
      begin bad++; $display("FAIL t6_b0 got=%b/%h exp=1/3c", st16, dt16); end
    cyc(2);
    pulse_done16();
    total++; if (st16 !== 1'b1 || dt16 !== 8'h0F)
      begin bad++; $display("FAIL t6_b1 got=%b/%h exp=1/0f", st16, dt16); end
    cyc(2);
    pulse_done16();
    total++; if (st16 !== 1'b1 || dt16 !== 8'h33 || b16 !== 1'b1)
      begin bad++; $display("FAIL t6_csum got=%b/%h/%b exp=1/33/1", st16, dt16, b16); end
    cyc(2);
    pulse_done16();
    total++; if (b16 !== 1'b0) begin bad++; $display("FAIL t6_busy_fall got=%b exp=0", b16); end
`endif
  endtask

  initial begin
    test_reset();
    test_single_byte();
    test_two_bytes();
    test_overrun();
    test_reset_mid();
    test_spurious_done();
    test_checksum();
    cyc(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
